xs3_conv_seq: RTL and testbench

- Parametrised, sequential multi-digit excess-3 code converter; successor to the team's single-digit combinational 4-bit BCD-to-XS3 converter.
- Converts a packed word of DIGITS 4-bit digits in either direction, selected per transaction: BCD->XS3 or XS3->BCD.
- Processes one digit per clock, LSB digit first, and flags invalid codes per digit.
- Sits between BCD datapath stages and display/arithmetic units, with valid/ready handshakes on both sides.

---
 rtl/xs3_conv_seq_if.sv | 27 ++
 rtl/xs3_conv_seq.sv | 123 ++++++++++++
 tb/tb_xs3_conv_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/xs3_conv_seq_if.sv
// rtl/xs3_conv_seq_if.sv - handshake bundle for the multi-digit excess-3 converter
interface xs3_conv_seq_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  mode;
  logic [4*DIGITS-1:0]   din;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   dout;
  logic [DIGITS-1:0]     err_mask;
  logic                  err;
  logic                  busy;

  // upstream/downstream driver side
  modport master (
    output in_valid, mode, din, out_ready,
    input  in_ready, out_valid, dout, err_mask, err, busy
  );

  // converter side
  modport slave (
    input  in_valid, mode, din, out_ready,
    output in_ready, out_valid, dout, err_mask, err, busy
  );
endinterface

// File: rtl/xs3_conv_seq.sv
// rtl/xs3_conv_seq.sv - sequential multi-digit BCD<->XS3 converter, one digit per clock
module xs3_conv_seq #(
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  xs3_conv_seq_if.slave bus
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   din_q, din_d;
  logic                  mode_q, mode_d;
  logic [4*DIGITS-1:0]   dout_q, dout_d;
  logic [DIGITS-1:0]     err_mask_q, err_mask_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [3:0]            cur_digit;
  logic [4:0]            cur_res;

  // Single-digit conversion; returns {invalid, value}. Invalid codes map to 4'hF.
  function automatic logic [4:0] conv_digit(input logic m, input logic [3:0] d);
    logic [4:0] r;
    if (!m) begin
      if (d <= 4'd9) r = {1'b0, d + 4'd3};
      else           r = {1'b1, 4'hF};
    end else begin
      if (d >= 4'd3 && d <= 4'd12) r = {1'b0, d - 4'd3};
      else                         r = {1'b1, 4'hF};
    end
    return r;
  endfunction

  // Select the digit addressed by the index and convert it.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == CW'(i)) cur_digit = din_q[4*i +: 4];
    end
    cur_res = conv_digit(mode_q, cur_digit);
  end

  // Next-state and next-output computation for the IDLE/CONV/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    din_d      = din_q;
    mode_d     = mode_q;
    dout_d     = dout_q;
    err_mask_d = err_mask_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = CONV;
          din_d      = bus.din;
          mode_d     = bus.mode;
          dout_d     = '0;
          err_mask_d = '0;
          idx_d      = '0;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == CW'(i)) begin
            dout_d[4*i +: 4] = cur_res[3:0];
            err_mask_d[i]    = cur_res[4];
          end
        end
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + CW'(1);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d       = |err_mask_d;
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; asynchronous reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      din_q       <= '0;
      mode_q      <= 1'b0;
      dout_q      <= '0;
      err_mask_q  <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      din_q       <= din_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      err_mask_q  <= err_mask_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.err_mask  = err_mask_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_xs3_conv_seq.sv
// tb/tb_xs3_conv_seq.sv - self-checking bench for xs3_conv_seq (DIGITS=4 and DIGITS=1)
module tb_xs3_conv_seq;
  typedef struct {
    logic        m;
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] mask;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] dout;
    logic [15:0] mask;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv4 = 1'b0;
  logic        iv1 = 1'b0;
  logic        mode_r = 1'b0;
  logic [15:0] din_r = 16'h0;
  logic        out_ready_r = 1'b0;
  bit          sel = 1'b0;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  vec_t vt[7];

  logic        o_ir, o_ov, o_err, o_busy;
  logic [15:0] o_dout, o_mask;

  xs3_conv_seq_if #(.DIGITS(4)) b4();
  xs3_conv_seq_if #(.DIGITS(1)) b1();

  xs3_conv_seq #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  xs3_conv_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b4.in_valid  = iv4;
  assign b4.mode      = mode_r;
  assign b4.din       = din_r;
  assign b4.out_ready = out_ready_r;
  assign b1.in_valid  = iv1;
  assign b1.mode      = mode_r;
  assign b1.din       = din_r[3:0];
  assign b1.out_ready = out_ready_r;

  always #5 clk = ~clk;

  always_comb begin
    if (sel) begin
      o_ir = b1.in_ready; o_ov = b1.out_valid; o_err = b1.err; o_busy = b1.busy;
      o_dout = {12'h0, b1.dout}; o_mask = {15'h0, b1.err_mask};
    end else begin
      o_ir = b4.in_ready; o_ov = b4.out_valid; o_err = b4.err; o_busy = b4.busy;
      o_dout = b4.dout; o_mask = {12'h0, b4.err_mask};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input bit s, input logic m, input logic [15:0] d, input exp_t e);
    int n;
    sel = s;
    n = 0;
    while (!o_ir && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(o_ir), 32'd1);
    din_r  = d;
    mode_r = m;
    if (s) iv1 = 1'b1; else iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    iv1 = 1'b0;
    sb.push_back(e);
    din_r  = 16'($urandom);
    mode_r = ~m;
  endtask

  task automatic wait_out(input bit s);
    int lat;
    sel = s;
    lat = 0;
    while (!o_ov && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), s ? 32'd1 : 32'd4);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("dout", 32'(o_dout), 32'(e.dout));
      check("err_mask", 32'(o_mask), 32'(e.mask));
      check("err", 32'(o_err), 32'(e.err));
      check("busy_done", 32'(o_busy), 32'd1);
      check("in_ready_done", 32'(o_ir), 32'd0);
    end
  endtask

  task automatic handshake();
    out_ready_r = 1'b1;
    @(posedge clk); #1;
    out_ready_r = 1'b0;
    check("out_valid_after_hs", 32'(o_ov), 32'd0);
    check("in_ready_after_hs", 32'(o_ir), 32'd1);
  endtask

  task automatic run_word(input bit s, input logic m, input logic [15:0] d, input exp_t e);
    accept(s, m, d, e);
    wait_out(s);
    pop_check();
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vt[0] = '{1'b0, 16'h1234, 16'h4567, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 16'hC333, 16'h9000, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 16'h12A9, 16'h45FC, 16'h0002, 1'b1};
    vt[3] = '{1'b1, 16'h3C21, 16'h09FF, 16'h0003, 1'b1};
    vt[4] = '{1'b0, 16'h9999, 16'hCCCC, 16'h0000, 1'b0};
    vt[5] = '{1'b1, 16'h0FC3, 16'hFF90, 16'h000C, 1'b1};
    vt[6] = '{1'b0, 16'hFA00, 16'hFF33, 16'h000C, 1'b1};

    // reset state
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(o_ov), 32'd0);
    check("rst_dout", 32'(o_dout), 32'd0);
    check("rst_err_mask", 32'(o_mask), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(o_ir), 32'd1);
    check("in_ready_after_rst_d1", 32'(b1.in_ready), 32'd1);

    // table vectors; din/mode are scrambled during CONV inside accept
    for (int i = 0; i < 7; i++) begin
      e.dout = vt[i].dout; e.mask = vt[i].mask; e.err = vt[i].err;
      run_word(1'b0, vt[i].m, vt[i].din, e);
    end

    // backpressure: result held, new in_valid ignored while in DONE
    e.dout = 16'h4567; e.mask = 16'h0; e.err = 1'b0;
    accept(1'b0, 1'b0, 16'h1234, e);
    wait_out(1'b0);
    pop_check();
    for (int k = 0; k < 5; k++) begin
      iv4 = 1'b1; din_r = 16'h0000; mode_r = 1'b0;
      @(posedge clk); #1;
      check("bp_dout", 32'(o_dout), 32'h4567);
      check("bp_err", 32'(o_err), 32'd0);
      check("bp_in_ready", 32'(o_ir), 32'd0);
      check("bp_out_valid", 32'(o_ov), 32'd1);
    end
    iv4 = 1'b0;
    handshake();
    check("bp_busy_idle", 32'(o_busy), 32'd0);
    check("bp_dout_hold", 32'(o_dout), 32'h4567);
    e.dout = 16'h09FF; e.mask = 16'h3; e.err = 1'b1;
    run_word(1'b0, 1'b1, 16'h3C21, e);

    // reset on the second CONV cycle
    e.dout = 16'h89AB; e.mask = 16'h0; e.err = 1'b0;
    accept(1'b0, 1'b0, 16'h5678, e);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(o_ov), 32'd0);
    check("abort_dout", 32'(o_dout), 32'd0);
    check("abort_err_mask", 32'(o_mask), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_in_ready", 32'(o_ir), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e.dout = 16'h3C3C; e.mask = 16'h0; e.err = 1'b0;
    run_word(1'b0, 1'b0, 16'h0909, e);

    // single-digit build
    e.dout = 16'h000C; e.mask = 16'h0; e.err = 1'b0;
    run_word(1'b1, 1'b0, 16'h0009, e);
    e.dout = 16'h000F; e.mask = 16'h1; e.err = 1'b1;
    run_word(1'b1, 1'b1, 16'h0002, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
